// File: rtl/lfsr_pattern_checker.sv
// Receive-side LFSR pattern checker: self-seeds from the stream, locks, then counts errors.
// Optional macro LFSR_CHK_ZERO_DET_EN rejects all-zero seeds and adds a sticky zero_err output.
module lfsr_pattern_checker #(
    parameter int unsigned LOCK_COUNT  = 2,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       tap,
    input  logic             start,
    input  logic             stop,
    input  logic             pat_valid,
    input  logic [0:7]       pat,
    output logic             pat_ready,
    output logic             locked,
    output logic             err_pulse,
    output logic             lost_lock,
    output logic [0:7]       exp_pat,
    output logic [CNT_W-1:0] pat_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] hd_sum
`ifdef LFSR_CHK_ZERO_DET_EN
    ,
    output logic             zero_err
`endif
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSeed   = 2'd1;
    localparam logic [1:0] StAcq    = 2'd2;
    localparam logic [1:0] StLocked = 2'd3;

    localparam int unsigned MR_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MS_W = $clog2(LOSS_THRESH + 1);
    localparam logic [MR_W-1:0] LockLast = MR_W'(LOCK_COUNT - 1);
    localparam logic [MS_W-1:0] LossLast = MS_W'(LOSS_THRESH - 1);

    function automatic logic [0:7] lfsr_next(input logic [0:7] p, input logic [6:0] t);
        logic [0:7] n;
        n[0] = p[7];
        for (int i = 1; i < 8; i++) begin
            n[i] = p[i-1] ^ (t[7-i] & p[7]);
        end
        return n;
    endfunction

    function automatic logic [3:0] popcount8(input logic [0:7] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [0:7]       exp_q, exp_d;
    logic [6:0]       tap_q, tap_d;
    logic [MR_W-1:0]  match_q, match_d;
    logic [MS_W-1:0]  miss_q, miss_d;
    logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] hd_q, hd_d;
    logic             err_pulse_q, err_pulse_d;
    logic             lost_q, lost_d;

    logic             beat;
    logic             mismatch;
    logic             seed_ok;
    logic [3:0]       pc;
    logic [CNT_W:0]   hd_add;

    assign pat_ready = (state_q != StIdle);
    assign beat      = pat_valid & pat_ready;
    assign mismatch  = (pat != exp_q);
    assign pc        = popcount8(pat ^ exp_q);
    assign hd_add    = {1'b0, hd_q} + (CNT_W + 1)'(pc);

`ifdef LFSR_CHK_ZERO_DET_EN
    logic zero_err_q;

    assign seed_ok = (pat != '0);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            zero_err_q <= 1'b0;
        end else if (beat && !stop && !seed_ok && (state_q == StSeed || state_q == StAcq)) begin
            zero_err_q <= 1'b1;
        end
    end

    assign zero_err = zero_err_q;
`else
    assign seed_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        tap_d       = tap_q;
        match_d     = match_q;
        miss_d      = miss_q;
        pat_cnt_d   = pat_cnt_q;
        err_cnt_d   = err_cnt_q;
        hd_d        = hd_q;
        err_pulse_d = 1'b0;
        lost_d      = 1'b0;

        if (start) begin
            state_d   = StSeed;
            tap_d     = tap;
            match_d   = '0;
            miss_d    = '0;
            pat_cnt_d = '0;
            err_cnt_d = '0;
            hd_d      = '0;
        end else if (stop) begin
            state_d = StIdle;
        end else if (beat) begin
            unique case (state_q)
                StSeed: begin
                    if (seed_ok) begin
                        exp_d   = lfsr_next(pat, tap_q);
                        match_d = '0;
                        state_d = StAcq;
                    end
                end
                StAcq: begin
                    if (seed_ok) begin
                        exp_d = lfsr_next(pat, tap_q);
                        if (mismatch) begin
                            match_d = '0;
                        end else if (match_q == LockLast) begin
                            match_d = '0;
                            miss_d  = '0;
                            state_d = StLocked;
                        end else begin
                            match_d = match_q + MR_W'(1);
                        end
                    end
                end
                StLocked: begin
                    // Prediction free-runs so a corrupted beat cannot poison the next one.
                    exp_d     = lfsr_next(exp_q, tap_q);
                    pat_cnt_d = (pat_cnt_q == '1) ? pat_cnt_q : pat_cnt_q + CNT_W'(1);
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
                        hd_d        = hd_add[CNT_W] ? '1 : hd_add[CNT_W-1:0];
                        if (miss_q == LossLast) begin
                            miss_d  = '0;
                            match_d = '0;
                            lost_d  = 1'b1;
                            exp_d   = lfsr_next(pat, tap_q);
                            state_d = StAcq;
                        end else begin
                            miss_d = miss_q + MS_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            exp_q       <= '0;
            tap_q       <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            pat_cnt_q   <= '0;
            err_cnt_q   <= '0;
            hd_q        <= '0;
            err_pulse_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            tap_q       <= tap_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            pat_cnt_q   <= pat_cnt_d;
            err_cnt_q   <= err_cnt_d;
            hd_q        <= hd_d;
            err_pulse_q <= err_pulse_d;
            lost_q      <= lost_d;
        end
    end

    assign locked    = (state_q == StLocked);
    assign err_pulse = err_pulse_q;
    assign lost_lock = lost_q;
    assign exp_pat   = exp_q;
    assign pat_cnt   = pat_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign hd_sum    = hd_q;

endmodule

// File: tb/tb_lfsr_pattern_checker.sv
// Bench for lfsr_pattern_checker: directed vector table, saturation run, then random traffic
// against an arithmetic reference model. Honours LFSR_CHK_ZERO_DET_EN when defined.
module tb_lfsr_pattern_checker;

    localparam int unsigned CW    = 6;
    localparam int          LOCKN = 2;
    localparam int          LOSSN = 4;
    localparam int          MAXC  = (1 << CW) - 1;
    localparam int          VW    = 13 + 3 * CW;
`ifdef LFSR_CHK_ZERO_DET_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, stop, pat_valid;
    logic [6:0]    tap;
    logic [0:7]    pat;
    logic          pat_ready, locked, err_pulse, lost_lock;
    logic [0:7]    exp_pat;
    logic [CW-1:0] pat_cnt, err_cnt, hd_sum;
    logic          dut_zero;

    lfsr_pattern_checker #(
        .LOCK_COUNT (LOCKN),
        .LOSS_THRESH(LOSSN),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tap      (tap),
        .start    (start),
        .stop     (stop),
        .pat_valid(pat_valid),
        .pat      (pat),
        .pat_ready(pat_ready),
        .locked   (locked),
        .err_pulse(err_pulse),
        .lost_lock(lost_lock),
        .exp_pat  (exp_pat),
        .pat_cnt  (pat_cnt),
        .err_cnt  (err_cnt),
        .hd_sum   (hd_sum)
`ifdef LFSR_CHK_ZERO_DET_EN
        ,
        .zero_err (dut_zero)
`endif
    );
`ifndef LFSR_CHK_ZERO_DET_EN
    assign dut_zero = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: patterns held as integers with the leftmost literal bit as MSB.
    int         m_mode;  // 0 idle, 1 seed, 2 acquire, 3 locked
    logic [7:0] m_exp;
    logic [6:0] m_tap;
    int         m_match, m_miss, m_pcnt, m_ecnt, m_hd;
    bit         m_err, m_lost, m_zero;

    function automatic logic [7:0] ref_next(input logic [7:0] v, input logic [6:0] t);
        logic [7:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ {1'b1, t};
        return s;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [VW-1:0] pack(input bit rdy, input bit lk, input bit ep, input bit ll,
                                           input logic [7:0] ex, input int pc, input int ec,
                                           input int hd, input bit z);
        return {rdy, lk, ep, ll, ex, pc[CW-1:0], ec[CW-1:0], hd[CW-1:0], z};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {pat_ready, locked, err_pulse, lost_lock, exp_pat, pat_cnt, err_cnt, hd_sum,
                dut_zero};
    endfunction

    task automatic model_step();
        logic [7:0] p;
        p      = pat;
        m_err  = 1'b0;
        m_lost = 1'b0;
        if (rst) begin
            m_mode = 0; m_exp = '0; m_tap = '0; m_match = 0; m_miss = 0;
            m_pcnt = 0; m_ecnt = 0; m_hd = 0; m_zero = 1'b0;
        end else if (start) begin
            m_mode = 1; m_tap = tap; m_match = 0; m_miss = 0;
            m_pcnt = 0; m_ecnt = 0; m_hd = 0; m_zero = 1'b0;
        end else if (stop) begin
            m_mode = 0;
        end else if (pat_valid && m_mode != 0) begin
            if (m_mode != 3 && ZD && p == 8'h00) begin
                m_zero = 1'b1;
            end else if (m_mode == 1) begin
                m_exp = ref_next(p, m_tap); m_match = 0; m_mode = 2;
            end else if (m_mode == 2) begin
                m_match = (p == m_exp) ? m_match + 1 : 0;
                m_exp   = ref_next(p, m_tap);
                if (m_match >= LOCKN) begin
                    m_mode = 3; m_miss = 0; m_match = 0;
                end
            end else begin
                m_pcnt = sat(m_pcnt + 1);
                if (p != m_exp) begin
                    m_err  = 1'b1;
                    m_ecnt = sat(m_ecnt + 1);
                    m_hd   = sat(m_hd + $countones(p ^ m_exp));
                    m_miss = m_miss + 1;
                end else begin
                    m_miss = 0;
                end
                if (m_miss >= LOSSN) begin
                    m_mode = 2; m_lost = 1'b1; m_miss = 0; m_match = 0;
                    m_exp  = ref_next(p, m_tap);
                end else begin
                    m_exp = ref_next(m_exp, m_tap);
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        logic [VW-1:0] w;
        w = pack(m_mode != 0, m_mode == 3, m_err, m_lost, m_exp, m_pcnt, m_ecnt, m_hd, m_zero);
        checks++;
        if (dut_vec() !== w) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, dut_vec(), w);
        end
    endtask

    typedef struct {
        logic          rst, start, stop, valid;
        logic [7:0]    pat;
        logic [VW-1:0] expv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic sp, input logic v,
                       input logic [7:0] pt, input bit rdy, input bit lk, input bit ep,
                       input bit ll, input logic [7:0] ex, input int pc, input int ec,
                       input int hd, input bit z);
        vec_t e;
        e.rst = r; e.start = s; e.stop = sp; e.valid = v; e.pat = pt;
        e.expv = pack(rdy, lk, ep, ll, ex, pc, ec, hd, z);
        vecs.push_back(e);
    endtask

    logic [7:0] gen;
    logic [7:0] pv;
    int         cpct;
    bit         acc;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pat_valid = 1'b0; pat = '0; tap = 7'h25;

        //   rst start stop valid pat    rdy lk ep ll exp   pc ec hd zero
        add(1, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 1, 8'h99, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h99, 1, 0, 0, 0, 8'hE9, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'hE9, 1, 0, 0, 0, 8'hD1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'hD1, 1, 1, 0, 0, 8'hCD, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h12, 1, 1, 0, 0, 8'hCD, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h0D, 1, 1, 1, 0, 8'hC3, 1, 1, 2, 0);
        add(0, 0, 0, 1, 8'hC3, 1, 1, 0, 0, 8'hC4, 2, 1, 2, 0);
        add(0, 0, 0, 1, 8'h00, 1, 1, 1, 0, 8'h62, 3, 2, 5, 0);
        add(0, 0, 0, 1, 8'h00, 1, 1, 1, 0, 8'h31, 4, 3, 8, 0);
        add(0, 0, 0, 1, 8'h00, 1, 1, 1, 0, 8'hBD, 5, 4, 11, 0);
        add(0, 0, 0, 1, 8'h01, 1, 0, 1, 1, 8'hA5, 6, 5, 16, 0);
        add(0, 0, 0, 1, 8'hA5, 1, 0, 0, 0, 8'hF7, 6, 5, 16, 0);
        add(0, 0, 0, 1, 8'hF7, 1, 1, 0, 0, 8'hDE, 6, 5, 16, 0);
        add(0, 1, 0, 1, 8'hDE, 1, 0, 0, 0, 8'hDE, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h99, 1, 0, 0, 0, 8'hE9, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'hE9, 1, 0, 0, 0, 8'hD1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'hD1, 1, 1, 0, 0, 8'hCD, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h0D, 1, 1, 1, 0, 8'hC3, 1, 1, 2, 0);
        add(0, 0, 1, 1, 8'hC3, 0, 0, 0, 0, 8'hC3, 1, 1, 2, 0);
        add(0, 0, 0, 1, 8'h55, 0, 0, 0, 0, 8'hC3, 1, 1, 2, 0);
        add(0, 1, 1, 1, 8'h55, 1, 0, 0, 0, 8'hC3, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h00, 1, 0, 0, 0, ZD ? 8'hC3 : 8'h00, 0, 0, 0, ZD);
        add(0, 0, 0, 1, 8'h99, 1, 0, 0, 0, 8'hE9, 0, 0, 0, ZD);
        add(0, 1, 0, 0, 8'h99, 1, 0, 0, 0, 8'hE9, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            pat_valid = vecs[i].valid; pat = vecs[i].pat;
            tick();
            checks++;
            if (dut_vec() !== vecs[i].expv) begin
                failures++;
                $display("FAIL vec%0d got=%h want=%h", i, dut_vec(), vecs[i].expv);
            end
        end

        // Long locked run with 3-in-4 errors: all three counters must pin at all-ones.
        rst = 1'b0; stop = 1'b0; start = 1'b1; pat_valid = 1'b0; tap = 7'h25;
        tick();
        check_model("sat_start");
        start = 1'b0; pat_valid = 1'b1; gen = 8'h99;
        for (int i = 0; i < 130; i++) begin
            pat = (i < 3 || i % 4 == 3) ? gen : gen ^ 8'h0F;
            tick();
            check_model("sat_run");
            gen = ref_next(gen, 7'h25);
        end
        checks++;
        if ({pat_cnt, err_cnt, hd_sum} !== {3{MAXC[CW-1:0]}}) begin
            failures++;
            $display("FAIL sat_clamp got=%h want=%h", {pat_cnt, err_cnt, hd_sum},
                     {3{MAXC[CW-1:0]}});
        end

        // Random traffic: mostly a clean generator stream with configurable corruption.
        cpct = 5;
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            start     = (c == 0) || ($urandom_range(0, 199) == 0);
            stop      = ($urandom_range(0, 299) == 0);
            pat_valid = ($urandom_range(0, 9) < 8);
            if (start) begin
                tap = 7'($urandom);
                gen = 8'($urandom_range(1, 255));
                case ($urandom_range(0, 2))
                    0:       cpct = 0;
                    1:       cpct = 5;
                    default: cpct = 40;
                endcase
            end
            if ($urandom_range(0, 99) < cpct) begin
                pv = ($urandom_range(0, 3) == 0) ? 8'h00 : gen ^ 8'($urandom_range(1, 255));
            end else begin
                pv = gen;
            end
            pat = pv;
            acc = !rst && !start && !stop && pat_valid && (m_mode != 0);
            tick();
            check_model("rand");
            if (acc) gen = ref_next(gen, m_tap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
